// File: rtl/ahtbe_egress_sched.sv
// ahtbe_egress_sched: congestion-aware round-robin scheduler for the telemetry egress port
module ahtbe_egress_sched #(
  parameter int N         = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4,
  parameter int GAP       = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [N-1:0]                       req_valid,
  input  logic [N*DW-1:0]                    req_data,
  output logic [N-1:0]                       req_ready,
  input  logic [N-1:0]                       lowpri_mask,
  input  logic                               congestion,
  output logic                               out_valid,
  output logic [DW-1:0]                      out_data,
  input  logic                               out_ready,
  output logic                               grant_active,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_id,
  output logic [15:0]                        throttle_cnt
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;
  state_t state, state_n;
  logic [IW-1:0] ptr, ptr_n, grant_id_n, sel, idx;
  logic [3:0] burst_cnt, burst_n, gap_cnt, gap_n;
  logic [15:0] thr_n;
  logic [N-1:0] elig;
  logic found, hold, xfer, granted;
  // low-priority requesters drop out of eligibility in the same cycle congestion rises
  assign elig         = req_valid & ~(lowpri_mask & {N{congestion}});
  assign granted      = state == S_GRANT;
  assign hold         = elig[grant_id];
  assign xfer         = granted && hold && out_ready;
  assign out_valid    = granted && hold;
  assign out_data     = granted ? req_data[grant_id*DW +: DW] : '0;
  assign req_ready    = xfer ? (N'(1) << grant_id) : '0;
  assign grant_active = granted;
  // round-robin search starting after the last holder; nearest eligible wins
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (elig[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end
  // next-state: grant from idle, release on burst end or lost eligibility, gap countdown
  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    grant_id_n = grant_id;
    burst_n    = burst_cnt;
    gap_n      = gap_cnt;
    thr_n      = throttle_cnt;
    if (state == S_IDLE && found) begin
      state_n    = S_GRANT;
      grant_id_n = sel;
      burst_n    = '0;
    end else if (granted && (!hold || (xfer && burst_cnt == 4'(MAX_BURST - 1)))) begin
      ptr_n   = grant_id;
      state_n = congestion ? S_GAP : S_IDLE;
      gap_n   = congestion ? 4'(GAP - 1) : gap_cnt;
      thr_n   = (congestion && throttle_cnt != 16'hFFFF) ? throttle_cnt + 16'd1 : throttle_cnt;
    end else if (xfer) begin
      burst_n = burst_cnt + 4'd1;
    end else if (state == S_GAP) begin
      state_n = (gap_cnt == 4'd0) ? S_IDLE : S_GAP;
      gap_n   = (gap_cnt == 4'd0) ? gap_cnt : gap_cnt - 4'd1;
    end
  end
  // state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ptr          <= IW'(N - 1);
      grant_id     <= '0;
      burst_cnt    <= '0;
      gap_cnt      <= '0;
      throttle_cnt <= '0;
    end else begin
      state        <= state_n;
      ptr          <= ptr_n;
      grant_id     <= grant_id_n;
      burst_cnt    <= burst_n;
      gap_cnt      <= gap_n;
      throttle_cnt <= thr_n;
    end
  end
endmodule

// File: tb/tb_ahtbe_egress_sched.sv
// tb_ahtbe_egress_sched: randomized and directed checks against a transaction-level scheduler model
module tb_ahtbe_egress_sched;
  localparam int N = 4, DW = 8, MB = 4, G = 3;
  logic clk = 1'b0, rst_n = 1'b0, cong = 1'b0, ord = 1'b0;
  logic [N-1:0] vld = '0, low = '0, rdy;
  logic [N*DW-1:0] dat = '0;
  logic ov, ga;
  logic [DW-1:0] od;
  logic [1:0] gid;
  logic [15:0] thr;
  int total = 0, bad = 0;
  int m_hold, m_last, m_ptr, m_beats, m_gap, m_thr;
  bit s_beat, s_ga, s_ov, prev_ga;
  logic [1:0] s_gid;
  logic [15:0] s_thr;
  int grants[$];

  ahtbe_egress_sched #(.N(N), .DW(DW), .MAX_BURST(MB), .GAP(G)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(vld), .req_data(dat), .req_ready(rdy),
    .lowpri_mask(low), .congestion(cong), .out_valid(ov), .out_data(od), .out_ready(ord),
    .grant_active(ga), .grant_id(gid), .throttle_cnt(thr));

  always #5 clk = ~clk;

  function automatic bit el(int i);
    return vld[i] && !(cong && low[i]);
  endfunction

  function automatic void model_reset();
    m_hold = -1; m_last = 0; m_ptr = N - 1; m_beats = 0; m_gap = 0; m_thr = 0;
  endfunction

  function automatic void model_release();
    m_ptr = m_hold;
    m_hold = -1;
    if (cong) begin
      m_gap = G;
      if (m_thr < 65535) m_thr++;
    end
  endfunction

  task automatic step();
    bit ev, eg, fnd;
    logic [DW-1:0] ed;
    logic [N-1:0] er;
    int h;
    #1;
    eg = m_hold >= 0;
    ev = eg && el(m_hold);
    ed = eg ? dat[m_hold*DW +: DW] : '0;
    er = (ev && ord) ? (N'(1) << m_hold) : '0;
    total += 6;
    if (ov !== ev) begin bad++; $display("FAIL out_valid t=%0t got=%b exp=%b", $time, ov, ev); end
    if (od !== ed) begin bad++; $display("FAIL out_data t=%0t got=%h exp=%h", $time, od, ed); end
    if (rdy !== er) begin bad++; $display("FAIL req_ready t=%0t got=%b exp=%b", $time, rdy, er); end
    if (ga !== eg) begin bad++; $display("FAIL grant_active t=%0t got=%b exp=%b", $time, ga, eg); end
    if (gid !== 2'(m_last)) begin bad++; $display("FAIL grant_id t=%0t got=%0d exp=%0d", $time, gid, m_last); end
    if (thr !== 16'(m_thr)) begin bad++; $display("FAIL throttle_cnt t=%0t got=%h exp=%h", $time, thr, m_thr); end
    s_beat = ov && ord; s_ga = ga; s_ov = ov; s_gid = gid; s_thr = thr;
    if (ga && !prev_ga) grants.push_back(int'(gid));
    prev_ga = ga;
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (m_hold >= 0) begin
      if (!el(m_hold)) model_release();
      else if (ord) begin
        m_beats++;
        if (m_beats == MB) model_release();
      end
    end else if (m_gap > 0) m_gap--;
    else begin
      fnd = 0;
      for (int j = 1; j <= N; j++) begin
        h = (m_ptr + j) % N;
        if (!fnd && el(h)) begin fnd = 1; m_hold = h; m_last = h; m_beats = 0; end
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) dat[i*DW +: DW] = 8'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    prev_ga = 0;
    step();
    rst_n = 1'b1;
    grants.delete();
  endtask

  task automatic test_reset();
    vld = '1; low = '0; cong = 0; ord = 1; rand_data();
    do_reset();
    total++;
    if (s_ov !== 0 || s_ga !== 0 || s_thr !== 0) begin bad++; $display("FAIL reset_outputs ov=%b ga=%b thr=%h exp 0", s_ov, s_ga, s_thr); end
    step();
    total++;
    if (s_ga !== 0) begin bad++; $display("FAIL reset_idle_cycle ga=%b exp 0", s_ga); end
    step();
    total++;
    if (s_ga !== 1 || s_gid !== 0 || s_beat !== 1) begin bad++; $display("FAIL reset_first_grant ga=%b gid=%0d beat=%b exp 1/0/1", s_ga, s_gid, s_beat); end
  endtask

  task automatic test_round_robin();
    int beats = 0;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    vld = '1; low = '0; cong = 0; ord = 1;
    do_reset();
    for (int c = 0; c < 25; c++) begin
      rand_data();
      step();
      if (c < 20 && s_beat) beats++;
    end
    total++;
    if (beats != 16) begin bad++; $display("FAIL rr_throughput beats=%0d exp 16", beats); end
    total++;
    if (grants.size() < 5) begin bad++; $display("FAIL rr_grant_count got=%0d exp>=5", grants.size()); end
    else for (int i = 0; i < 5; i++) begin
      total++;
      if (grants[i] != exp_order[i]) begin bad++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, grants[i], exp_order[i]); end
    end
  endtask

  task automatic test_congestion();
    vld = '1; low = 4'b1010; cong = 1; ord = 1;
    do_reset();
    for (int c = 0; c < 40; c++) begin rand_data(); step(); end
    total++;
    if (grants.size() != 5) begin bad++; $display("FAIL cong_grant_count got=%0d exp 5", grants.size()); end
    foreach (grants[i]) begin
      total++;
      if (grants[i] != 0 && grants[i] != 2) begin bad++; $display("FAIL cong_lowpri_granted got=%0d exp 0 or 2", grants[i]); end
    end
    total++;
    if (s_thr !== 16'd5) begin bad++; $display("FAIL cong_throttle got=%0d exp 5", s_thr); end
  endtask

  task automatic test_demotion();
    vld = 4'b1110; low = 4'b0010; cong = 0; ord = 1; rand_data();
    do_reset();
    step(); step(); step();
    cong = 1;
    step();
    total++;
    if (s_ov !== 0 || s_ga !== 1 || s_gid !== 1) begin bad++; $display("FAIL demote_drop ov=%b ga=%b gid=%0d exp 0/1/1", s_ov, s_ga, s_gid); end
    for (int c = 0; c < 6; c++) step();
    total++;
    if (grants.size() != 2 || grants[1] != 2) begin bad++; $display("FAIL demote_next_grant n=%0d last=%0d exp 2", grants.size(), grants[grants.size()-1]); end
  endtask

  task automatic test_backpressure();
    int beats = 0;
    vld = '1; low = '0; cong = 0; ord = 1; rand_data();
    do_reset();
    step();
    for (int c = 0; c < 2; c++) begin step(); if (s_beat && s_gid == 0) beats++; end
    ord = 0;
    for (int c = 0; c < 5; c++) begin
      rand_data();
      step();
      total++;
      if (s_ga !== 1 || s_gid !== 0) begin bad++; $display("FAIL bp_hold ga=%b gid=%0d exp 1/0", s_ga, s_gid); end
    end
    ord = 1;
    for (int c = 0; c < 6; c++) begin step(); if (s_beat && s_ga && s_gid == 0) beats++; end
    total++;
    if (beats != 4) begin bad++; $display("FAIL bp_burst_len got=%0d exp 4", beats); end
  endtask

  task automatic test_valid_drop();
    vld = '1; low = '0; cong = 0; ord = 1; rand_data();
    do_reset();
    step(); step();
    vld[0] = 0;
    for (int c = 0; c < 4; c++) step();
    total++;
    if (grants.size() != 2 || grants[1] != 1) begin bad++; $display("FAIL drop_next_grant n=%0d last=%0d exp 1", grants.size(), grants[grants.size()-1]); end
  endtask

  task automatic test_saturation();
    vld = 4'b0001; low = '0; cong = 1; ord = 1; rand_data();
    do_reset();
    force dut.throttle_cnt = 16'hFFFE;
    #1;
    release dut.throttle_cnt;
    m_thr = 65534;
    for (int c = 0; c < 20; c++) step();
    total++;
    if (s_thr !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp ffff", s_thr); end
  endtask

  task automatic test_random();
    vld = '1; low = '0; cong = 0; ord = 1;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      vld = N'($urandom) | N'($urandom);
      if ($urandom_range(0, 7) == 0) low = N'($urandom);
      if ($urandom_range(0, 9) == 0) cong = ~cong;
      ord = $urandom_range(0, 4) != 0;
      rst_n = $urandom_range(0, 79) != 0;
      rand_data();
      step();
    end
    rst_n = 1;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_congestion();
    test_demotion();
    test_backpressure();
    test_valid_drop();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
